// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub_pkg
//  Description : Shared mode encoding and signed-overflow helper for the
//                pipelined adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // Two's-complement overflow from the operand and result sign bits.
   function automatic logic calc_overflow(input logic x_msb,
                                          input logic y_msb,
                                          input logic z_msb,
                                          input logic mode);
      if (mode == MODE_ADD)
         return (x_msb == y_msb) && (z_msb != x_msb);
      else
         return (x_msb != y_msb) && (z_msb != x_msb);
   endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_add_sub
//  Description : Combinational W-bit add/subtract slice with carry/borrow
//                in and out. Subtraction is x + ~y + ~borrow_in; the
//                borrow out is the inverted carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_add_sub
   import add_sub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   input  logic         mode,
   output logic [W-1:0] s,
   output logic         c_out
);

   logic [W:0]   sum_w;
   logic [W-1:0] b_eff_w;
   logic         c_eff_w;

   // Fold subtraction into an addition of the inverted operand and borrow.
   always_comb begin
      b_eff_w = (mode == MODE_ADD) ? b    : ~b;
      c_eff_w = (mode == MODE_ADD) ? c_in : ~c_in;
      sum_w   = {1'b0, a} + {1'b0, b_eff_w} + {{W{1'b0}}, c_eff_w};
      s       = sum_w[W-1:0];
      c_out   = (mode == MODE_ADD) ? sum_w[W] : ~sum_w[W];
   end

endmodule
`default_nettype wire

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_add_sub
//  Description : N-bit adder/subtractor split into W-bit chunks, one chunk
//                per pipeline stage, with valid/ready handshakes, a global
//                advance enable and a signed-overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_add_sub
   import add_sub_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         bIn,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] z,
   output logic         b,
   output logic         v
);

   localparam int STAGES = N / W;

   logic         en;
   logic         valid_q [STAGES];
   logic         valid_d [STAGES];
   logic         mode_q  [STAGES];
   logic         mode_d  [STAGES];
   logic         carry_q [STAGES];
   logic         carry_d [STAGES];
   logic [N-1:0] x_q     [STAGES];
   logic [N-1:0] x_d     [STAGES];
   logic [N-1:0] y_q     [STAGES];
   logic [N-1:0] y_d     [STAGES];
   logic [N-1:0] z_q     [STAGES];
   logic [N-1:0] z_d     [STAGES];
   logic [W-1:0] chunk_s [STAGES];
   logic         chunk_c [STAGES];

   // Stage 0 works straight off the inputs; stage k uses the skewed
   // operands and the registered carry/borrow of stage k-1.
   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_head
            chunk_add_sub #(.W(W)) u_chunk (
               .a     (x[W-1:0]),
               .b     (y[W-1:0]),
               .c_in  (bIn),
               .mode  (mode),
               .s     (chunk_s[k]),
               .c_out (chunk_c[k])
            );
         end else begin : g_body
            chunk_add_sub #(.W(W)) u_chunk (
               .a     (x_q[k-1][k*W +: W]),
               .b     (y_q[k-1][k*W +: W]),
               .c_in  (carry_q[k-1]),
               .mode  (mode_q[k-1]),
               .s     (chunk_s[k]),
               .c_out (chunk_c[k])
            );
         end
      end
   endgenerate

   // Next-state of every stage: shift by one when the pipe may advance.
   always_comb begin
      en = !valid_q[STAGES-1] || out_ready;
      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = valid_q[k];
         mode_d[k]  = mode_q[k];
         carry_d[k] = carry_q[k];
         x_d[k]     = x_q[k];
         y_d[k]     = y_q[k];
         z_d[k]     = z_q[k];
      end
      if (en) begin
         // Bubbles carry all-zero data so idle outputs read as zero.
         valid_d[0] = in_valid;
         mode_d[0]  = in_valid ? mode : MODE_SUB;
         carry_d[0] = in_valid ? chunk_c[0] : 1'b0;
         x_d[0]     = in_valid ? x : '0;
         y_d[0]     = in_valid ? y : '0;
         z_d[0]     = '0;
         if (in_valid)
            z_d[0][W-1:0] = chunk_s[0];
         for (int k = 1; k < STAGES; k++) begin
            valid_d[k]          = valid_q[k-1];
            mode_d[k]           = mode_q[k-1];
            carry_d[k]          = chunk_c[k];
            x_d[k]              = x_q[k-1];
            y_d[k]              = y_q[k-1];
            z_d[k]              = z_q[k-1];
            z_d[k][k*W +: W]    = chunk_s[k];
         end
      end
   end

   // Stage registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            mode_q[k]  <= 1'b0;
            carry_q[k] <= 1'b0;
            x_q[k]     <= '0;
            y_q[k]     <= '0;
            z_q[k]     <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            mode_q[k]  <= mode_d[k];
            carry_q[k] <= carry_d[k];
            x_q[k]     <= x_d[k];
            y_q[k]     <= y_d[k];
            z_q[k]     <= z_d[k];
         end
      end
   end

   // Outputs come from the last stage; overflow needs only the sign bits.
   always_comb begin
      in_ready  = en;
      out_valid = valid_q[STAGES-1];
      z         = z_q[STAGES-1];
      b         = carry_q[STAGES-1];
      v         = calc_overflow(x_q[STAGES-1][N-1], y_q[STAGES-1][N-1],
                                z_q[STAGES-1][N-1], mode_q[STAGES-1]);
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_add_sub
//  Description : Directed-vector bench for pipelined_add_sub (16/4 and 4/4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

   typedef struct packed {
      logic        mode;
      logic [15:0] x;
      logic [15:0] y;
      logic        bin;
      logic [15:0] z;
      logic        b;
      logic        v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic        b_in = 1'b0;
   logic        mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] z;
   logic        b_out;
   logic        v;

   logic        in_valid1 = 1'b0;
   logic        in_ready1;
   logic [3:0]  x1 = '0;
   logic [3:0]  y1 = '0;
   logic        b_in1 = 1'b0;
   logic        mode1 = 1'b0;
   logic        out_valid1;
   logic        out_ready1 = 1'b1;
   logic [3:0]  z1;
   logic        b_out1;
   logic        v1;

   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   cyc = 0;
   int   ncons = 0;
   int   exp_q[$];
   int   dcyc[$];
   vec_t tbl[13];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_add_sub #(.N(16), .W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .bIn(b_in), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .z(z), .b(b_out), .v(v)
   );

   pipelined_add_sub #(.N(4), .W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .x(x1), .y(y1), .bIn(b_in1), .mode(mode1), .out_valid(out_valid1),
      .out_ready(out_ready1), .z(z1), .b(b_out1), .v(v1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Result monitor: every delivered result is matched against the next
   // expected table entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("stray", {31'd0, out_valid}, 32'd0);
         end else begin
            int id;
            id = exp_q.pop_front();
            chk("z", {16'd0, z}, {16'd0, tbl[id].z});
            chk("b", {31'd0, b_out}, {31'd0, tbl[id].b});
            chk("v", {31'd0, v}, {31'd0, tbl[id].v});
            dcyc.push_back(cyc);
            ncons++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id);
      logic acc;
      acc = 1'b0;
      x = tbl[id].x; y = tbl[id].y; b_in = tbl[id].bin; mode = tbl[id].mode;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      chk("send_accept", {31'd0, acc}, 32'd1);
      if (acc) exp_q.push_back(id);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] hz;
      logic        hb, hv;
      //          mode  x        y        bin   z        b     v
      tbl[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 16'h0002, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 16'h1000, 16'h2000, 1'b0, 16'hF000, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_z", {16'd0, z}, 32'd0);
      chk("rst_b", {31'd0, b_out}, 32'd0);
      chk("rst_v", {31'd0, v}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single operations with latency check: valid only after 3 more edges
      for (int i = 0; i < 5; i++) begin
         send(i);
         repeat (3) begin
            @(negedge clk);
            chk("latency_early", {31'd0, out_valid}, 32'd0);
            tick();
         end
         @(negedge clk);
         chk("latency_due", {31'd0, out_valid}, 32'd1);
         tick();
         tick();
      end
      chk("singles_done", ncons, 5);

      // Back-to-back mixed-mode stream
      for (int i = 5; i < 13; i++) send(i);
      wait_drain();
      chk("stream_count", ncons, 13);
      if (dcyc.size() == 13)
         chk("stream_consecutive", dcyc[12] - dcyc[5], 7);
      else
         chk("stream_deliveries", dcyc.size(), 13);

      // Backpressure after the 2nd result of a new stream
      fork
         begin
            for (int i = 5; i < 11; i++) send(i);
         end
         begin
            int seen;
            seen = 0;
            for (int t = 0; t < 60 && seen == 0; t++) begin
               tick();
               if (ncons >= 15) seen = 1;
            end
            chk("bp_second_seen", seen, 1);
            out_ready = 1'b0;
            hz = z; hb = b_out; hv = v;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            repeat (5) begin
               @(negedge clk);
               chk("bp_z_stable", {16'd0, z}, {16'd0, hz});
               chk("bp_bv_stable", {30'd0, b_out, v}, {30'd0, hb, hv});
               chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
               tick();
            end
            chk("bp_no_consume", ncons, 15);
            out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("bp_count", ncons, 19);

      // Reset with three operations in flight
      send(0); send(1); send(2);
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      chk("midrst_z", {16'd0, z}, 32'd0);
      repeat (8) begin
         @(negedge clk);
         chk("midrst_flush", {31'd0, out_valid}, 32'd0);
         tick();
      end

      // Single-stage instance (N=W=4): result one edge after accept
      x1 = 4'hF; y1 = 4'hF; b_in1 = 1'b1; mode1 = 1'b0; in_valid1 = 1'b1;
      @(negedge clk);
      chk("n4_in_ready", {31'd0, in_ready1}, 32'd1);
      tick();
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("n4_valid", {31'd0, out_valid1}, 32'd1);
      chk("n4_sub", {27'd0, z1, b_out1, v1}, {27'd0, 4'hF, 1'b1, 1'b0});
      tick();
      x1 = 4'h7; y1 = 4'h1; b_in1 = 1'b0; mode1 = 1'b1; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("n4_add", {26'd0, out_valid1, z1, b_out1, v1}, {26'd0, 1'b1, 4'h8, 1'b0, 1'b1});
      tick();
      x1 = 4'h8; y1 = 4'h1; b_in1 = 1'b0; mode1 = 1'b0; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("n4_sub_ovf", {26'd0, out_valid1, z1, b_out1, v1}, {26'd0, 1'b1, 4'h7, 1'b0, 1'b1});
      tick();
      @(negedge clk);
      chk("n4_drained", {31'd0, out_valid1}, 32'd0);

      chk("total_results", ncons, 19);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

- Parametrised, pipelined N-bit adder/subtractor with borrow/carry in and out and a signed-overflow flag.
- Generalises the team's combinational binary subtractor:
  - operand width N is split into W-bit chunks, one chunk per pipeline stage;
  - an add/subtract mode is selectable per operation;
  - operations are accepted and delivered through valid/ready handshakes with full backpressure.
- Sits in the datapath wherever wide arithmetic must meet timing at the system clock.

## Interface

- `N`, 16, operand/result width in bits; must be a multiple of `W`.
- `W`, 4, chunk width; the pipeline has `STAGES = N/W` stages (N == W gives one stage).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `in_valid`  in  1  operation presented on `x`, `y`, `bIn`, `mode`.
- `in_ready`  out  1  block accepts an operation this cycle.
- `x`  in  N  minuend / first addend.
- `y`  in  N  subtrahend / second addend.
- `bIn`  in  1  borrow-in (sub) / carry-in (add).
- `mode`  in  1  0 = subtract, 1 = add.
- `out_valid`  out  1  result on `z`, `b`, `v` is valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `z`  out  N  result modulo 2^N.
- `b`  out  1  borrow-out (sub) / carry-out (add).
- `v`  out  1  two's-complement signed overflow.

## Operation

- Subtract (`mode`=0): z = (x − y − bIn) mod 2^N; b = 1 iff x < y + bIn (unsigned); v = (x[N-1] != y[N-1]) && (z[N-1] != x[N-1]).
- Add (`mode`=1): z = (x + y + bIn) mod 2^N; b = carry out of bit N-1; v = (x[N-1] == y[N-1]) && (z[N-1] != x[N-1]).
- Stage k computes chunk k (bits kW+W-1..kW) from the registered borrow/carry of stage k-1; stage 0 uses `bIn`.
- Unprocessed upper operand chunks are skewed forward, and finished lower result chunks are deskewed, in per-stage registers.
- `mode` travels with each operation; operations of different modes may be freely interleaved.
- Each stage holds a valid bit; bubbles propagate as invalid entries.
- Global advance enable: `en = !out_valid || out_ready`. When `en`=1 every stage shifts by one; when 0 every stage holds.
- `in_ready = en`. An operation is accepted when `in_valid && in_ready`; `in_valid`=0 with `en`=1 inserts a bubble.
- No operation is ever dropped, duplicated or reordered.

## Timing

- Reset (`rst_n`=0 at a clock edge):
  - all stage valid bits and data registers clear to 0;
  - after that edge `out_valid`=0, `z`=0, `b`=0, `v`=0, and `in_ready`=1.
- Latency: an operation accepted at edge t appears with `out_valid`=1 after edge t+STAGES − 1 (N=16, W=4: STAGES=4, visible 4 cycles after the acceptance cycle).
- Throughput: one operation per cycle while `out_ready`=1.
- Stall (`out_valid`=1, `out_ready`=0):
  - `z`, `b`, `v` are held stable;
  - `in_ready`=0, and inputs presented that cycle are not taken.
- Simultaneous output handshake and new accept are allowed in the same cycle.
- Reset mid-operation: all in-flight operations are discarded; none emerges afterwards.
- Inputs are sampled only on accept; values on `x`/`y`/`bIn`/`mode` at other times are ignored.

## Structure

- Shared package `add_sub_pkg` holds:
  - the mode encoding constants `MODE_SUB`=0 and `MODE_ADD`=1;
  - a function computing the overflow flag from the operand MSBs, result MSB and mode.
- One sub-module, `chunk_add_sub`, is natural:
  - combinational W-bit add/sub of one chunk with carry/borrow in and out;
  - instantiated STAGES times via generate.
- The top level owns the skew/deskew registers, valid bits and the handshake.

## Test plan

Defaults N=16, W=4 unless stated otherwise.

- Reset then idle: `out_valid`=0, `z`=0, `in_ready`=1; sub x=FFFF, y=FFFF, bIn=1 → after 4 cycles z=FFFF, b=1, v=0.
- Sub x=8000, y=0001, bIn=0 → z=7FFF, b=0, v=1. Sub x=0002, y=0001 → z=0001, b=0, v=0.
- Add x=7FFF, y=0001 → z=8000, b=0, v=1. Add x=FFFF, y=0001, bIn=0 → z=0000, b=1, v=0.
- Stream 8 back-to-back mixed-mode operations with `out_ready`=1 → 8 correct results in order on consecutive cycles.
- Backpressure: hold `out_ready`=0 after the 2nd result for 5 cycles → `z`/`b`/`v` stable, `in_ready`=0; on release all remaining results arrive in order, none lost.
- Reset mid-operation: pull `rst_n` low for 1 cycle with 3 operations in flight → `out_valid`=0 thereafter and no stale result appears. Repeat the first vectors with N=4, W=4 (1 stage): x=1111, y=1111, bIn=1 → z=1111, b=1, v=0, one cycle after accept.
